// File: rtl/tl_lamp_driver.sv
// tl_lamp_driver: maps the controller phase code to road A/B lamps and
// inserts yellow and all-red clearance. Optional macro: TL_FAULT_FLASH_EN.
module tl_lamp_driver #(
   parameter int YEL_CYCLES   = 8,
   parameter int AR_CYCLES    = 4,
   parameter int BLINK_CYCLES = 16,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] state_code,
   output logic       la_r,
   output logic       la_y,
   output logic       la_g,
   output logic       la_left,
   output logic       lb_r,
   output logic       lb_y,
   output logic       lb_g,
   output logic       lb_left,
   output logic [2:0] phase,
   output logic       busy,
   output logic       fault
);

   typedef enum logic [1:0] {
      ST_STEADY,
      ST_YELLOW,
      ST_ALLRED,
      ST_FLASH
   } state_e;

   localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(AR_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLK_LD = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [2:0]       ALL_RED_CODE = 3'b100;
   localparam logic [7:0]       LAMP_AR = 8'b1000_1000;

   state_e           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [2:0]       code_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blink_q, blink_d;
   logic             busy_q, busy_d;
   logic             fault_q, fault_d;
   // {la_r, la_y, la_g, la_left, lb_r, lb_y, lb_g, lb_left}
   logic [7:0]       lamp_q, lamp_d;
   logic             code_ok;

   assign code_ok = (code_q <= ALL_RED_CODE);

   // Phase sequencing: steady display, yellow, all-red, fault flash.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      blink_d = blink_q;
      unique case (state_q)
         ST_STEADY: begin
            if (code_q != phase_q) begin
               if (!phase_q[2]) begin
                  state_d = ST_YELLOW;
                  cnt_d   = YEL_LD;
               end else if (code_ok) begin
                  phase_d = code_q;
               end
`ifdef TL_FAULT_FLASH_EN
               else begin
                  state_d = ST_FLASH;
                  cnt_d   = BLK_LD;
                  blink_d = 1'b1;
               end
`endif
            end
         end
         ST_YELLOW: begin
            if (cnt_q == '0) begin
               state_d = ST_ALLRED;
               cnt_d   = AR_LD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_ALLRED: begin
            if (cnt_q == '0) begin
               if (code_ok) begin
                  phase_d = code_q;
                  state_d = ST_STEADY;
               end else begin
                  phase_d = ALL_RED_CODE;
`ifdef TL_FAULT_FLASH_EN
                  state_d = ST_FLASH;
                  cnt_d   = BLK_LD;
                  blink_d = 1'b1;
`else
                  state_d = ST_STEADY;
`endif
               end
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_FLASH: begin
            phase_d = ALL_RED_CODE;
            if (code_ok) begin
               state_d = ST_ALLRED;
               cnt_d   = AR_LD;
            end else if (cnt_q == '0) begin
               blink_d = ~blink_q;
               cnt_d   = BLK_LD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: state_d = ST_STEADY;
      endcase
   end

   // Lamp pattern for the state about to be entered, so outputs are registered.
   always_comb begin
      lamp_d = LAMP_AR;
      unique case (state_d)
         ST_STEADY: begin
            unique case (phase_d)
               3'b000:  lamp_d = 8'b0010_1000;
               3'b001:  lamp_d = 8'b1001_1000;
               3'b010:  lamp_d = 8'b1000_0010;
               3'b011:  lamp_d = 8'b1000_1001;
               default: lamp_d = LAMP_AR;
            endcase
         end
         ST_YELLOW: begin
            if (!phase_d[1]) lamp_d = 8'b0100_1000;
            else             lamp_d = 8'b1000_0100;
         end
         ST_FLASH: lamp_d = {blink_d, 3'b000, blink_d, 3'b000};
         default:  lamp_d = LAMP_AR;
      endcase
      busy_d = (state_d == ST_YELLOW) || (state_d == ST_ALLRED);
`ifdef TL_FAULT_FLASH_EN
      fault_d = (state_d == ST_FLASH);
`else
      fault_d = 1'b0;
`endif
   end

   // State and output registers; reset shows all red.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_STEADY;
         phase_q <= ALL_RED_CODE;
         code_q  <= ALL_RED_CODE;
         cnt_q   <= '0;
         blink_q <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
         lamp_q  <= LAMP_AR;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         code_q  <= state_code;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
         lamp_q  <= lamp_d;
      end
   end

   assign {la_r, la_y, la_g, la_left, lb_r, lb_y, lb_g, lb_left} = lamp_q;
   assign phase = phase_q;
   assign busy  = busy_q;
   assign fault = fault_q;

endmodule

// File: tb/tb_tl_lamp_driver.sv
// tb_tl_lamp_driver: scoreboard bench for tl_lamp_driver.
// Vector: {fault, busy, phase, la_r/y/g/left, lb_r/y/g/left}.
module tb_tl_lamp_driver;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] state_code = 3'b100;
   logic       la_r, la_y, la_g, la_left;
   logic       lb_r, lb_y, lb_g, lb_left;
   logic [2:0] phase;
   logic       busy, fault;

   tl_lamp_driver #(
      .YEL_CYCLES(3), .AR_CYCLES(2), .BLINK_CYCLES(4), .CNT_W(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .state_code(state_code),
      .la_r(la_r), .la_y(la_y), .la_g(la_g), .la_left(la_left),
      .lb_r(lb_r), .lb_y(lb_y), .lb_g(lb_g), .lb_left(lb_left),
      .phase(phase), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   localparam logic [12:0] S100 = 13'b0_0_100_1000_1000;
   localparam logic [12:0] S000 = 13'b0_0_000_0010_1000;
   localparam logic [12:0] S001 = 13'b0_0_001_1001_1000;
   localparam logic [12:0] S010 = 13'b0_0_010_1000_0010;
   localparam logic [12:0] S011 = 13'b0_0_011_1000_1001;
   localparam logic [12:0] YA0  = 13'b0_1_000_0100_1000;
   localparam logic [12:0] YA1  = 13'b0_1_001_0100_1000;
   localparam logic [12:0] YB2  = 13'b0_1_010_1000_0100;
   localparam logic [12:0] YB3  = 13'b0_1_011_1000_0100;
   localparam logic [12:0] AR0  = 13'b0_1_000_1000_1000;
   localparam logic [12:0] AR1  = 13'b0_1_001_1000_1000;
   localparam logic [12:0] AR2  = 13'b0_1_010_1000_1000;
   localparam logic [12:0] AR3  = 13'b0_1_011_1000_1000;
   localparam logic [12:0] AR4  = 13'b0_1_100_1000_1000;
   localparam logic [12:0] FON  = 13'b1_0_100_1000_1000;
   localparam logic [12:0] FOFF = 13'b1_0_100_0000_0000;

   typedef struct {
      int          cyc;
      logic [12:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nmis = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs are presented every cycle; compare due entries.
   always @(negedge clk) begin
      logic [12:0] act;
      exp_t        e;
      act = {fault, busy, phase, la_r, la_y, la_g, la_left,
             lb_r, lb_y, lb_g, lb_left};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         nvec++;
         if (e.cyc != cyc) begin
            nmis++;
            $display("FAIL %s: cycle %0d check skipped (now %0d)",
                     e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            nmis++;
            $display("FAIL %s @%0d: got %b required %b",
                     e.name, cyc, act, e.val);
         end
      end
   end

   task automatic push(input int c, input logic [12:0] v,
                       input string nm);
      exp_t e;
      e.cyc = c; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full change: 1 latency, 3 yellow, 2 all-red, then new steady.
   task automatic trans(input logic [2:0] code, input logic [12:0] cur,
                        input logic [12:0] y, input logic [12:0] a,
                        input logic [12:0] fin, input string nm);
      int n;
      state_code = code;
      n = cyc;
      push(n + 1, cur, {nm, "_lat"});
      for (int i = 2; i <= 4; i++) push(n + i, y, {nm, "_yel"});
      for (int i = 5; i <= 6; i++) push(n + i, a, {nm, "_ar"});
      push(n + 7, fin, {nm, "_end"});
      step(7);
   endtask

   initial begin
      int n;
      step(3);
      push(cyc, S100, "reset");
      reset_n = 1'b1;
      push(cyc + 1, S100, "rel1");
      push(cyc + 2, S100, "rel2");
      step(2);

      state_code = 3'b000;
      n = cyc;
      push(n + 1, S100, "ar_to_g_lat");
      push(n + 2, S000, "ar_to_g");
      step(2);

      trans(3'b010, S000, YA0, AR0, S010, "a_to_b");
      trans(3'b001, S010, YB2, AR2, S001, "b_to_al");
      trans(3'b011, S001, YA1, AR1, S011, "al_to_bl");
      trans(3'b011 ^ 3'b011, S011, YB3, AR3, S000, "bl_to_a");

      state_code = 3'b010;
      n = cyc;
      push(n + 1, S000, "noab_lat");
      for (int i = 2; i <= 4; i++) push(n + i, YA0, "noab_yel");
      for (int i = 5; i <= 6; i++) push(n + i, AR0, "noab_ar");
      push(n + 7, S000, "noab_end");
      step(2);
      state_code = 3'b000;
      step(5);

      state_code = 3'b010;
      n = cyc;
      push(n + 1, S000, "rst_lat");
      push(n + 2, YA0, "rst_yel1");
      push(n + 3, S100, "rst_async");
      push(n + 4, S100, "rst_hold1");
      push(n + 5, S100, "rst_hold2");
      push(n + 6, S100, "rst_rel1");
      push(n + 7, S100, "rst_rel2");
      step(3);
      reset_n = 1'b0;
      state_code = 3'b100;
      step(2);
      reset_n = 1'b1;
      step(2);

      state_code = 3'b000;
      n = cyc;
      push(n + 1, S100, "post_rst_lat");
      push(n + 2, S000, "post_rst_g");
      step(2);

      trans(3'b010, S000, YA0, AR0, S010, "to_b");

      state_code = 3'b111;
      n = cyc;
      push(n + 1, S010, "inv_lat");
      for (int i = 2; i <= 4; i++) push(n + i, YB2, "inv_yel");
      for (int i = 5; i <= 6; i++) push(n + i, AR2, "inv_ar");
`ifdef TL_FAULT_FLASH_EN
      for (int i = 7; i <= 10; i++) push(n + i, FON, "flash_on");
      for (int i = 11; i <= 14; i++) push(n + i, FOFF, "flash_off");
      push(n + 15, FON, "flash_on2");
      push(n + 16, AR4, "flash_ar1");
      push(n + 17, AR4, "flash_ar2");
      push(n + 18, S100, "flash_exit");
`else
      for (int i = 7; i <= 18; i++) push(n + i, S100, "inv_as_ar");
`endif
      step(14);
      state_code = 3'b100;
      step(4);

      for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
      if (q.size() > 0) begin
         nmis += q.size();
         nvec += q.size();
         $display("FAIL drain: %0d checks never reached, 0 required",
                  q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
